piso_arb_ctrl: RTL and testbench

Round-robin scheduler and sequencer for a shared MSB-first parallel-in/serial-out shift register. Two requesters offer DW-bit words over valid/ready; the block grants one word at a time and drives the serializer's enable, load/shift and parallel-data inputs. It also emits frame markers aligned to the serializer's serial output. It sits between the word producers and the serializer instance and owns all of the serializer's control pins.

---
 rtl/piso_arb_ctrl_if.sv | 20 ++
 rtl/piso_arb_ctrl.sv | 92 +++++++++
 tb/tb_piso_arb_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_arb_ctrl_if.sv
// Word-producer side of the PISO scheduler: two valid/ready requesters.
// Handshake: a word transfers on a cycle where valid && ready; data is held while valid && !ready.
interface piso_arb_ctrl_if #(parameter int DW = 4);
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/piso_arb_ctrl.sv
// Round-robin word scheduler that owns the control pins of a shared MSB-first
// PISO shift register and flags frame boundaries on its serial output.
module piso_arb_ctrl #(
  parameter int DW = 4
) (
  input  logic           clk,
  input  logic           rst,
  piso_arb_ctrl_if.slave req,
  input  logic           stall,
  output logic           piso_enb,
  output logic           piso_l_s,
  output logic [DW-1:0]  piso_inp,
  output logic           frame_valid,
  output logic           sof,
  output logic           eof,
  output logic           grant_id,
  output logic           busy,
  output logic           dbg_state
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_grant, last_grant_nxt;
  logic          grant_id_nxt;
  logic          any_valid, winner, last_bit, load;

  always_comb begin
    any_valid = req.req0_valid | req.req1_valid;
    // On a tie the requester that did not win last time goes next.
    if (req.req0_valid && req.req1_valid) winner = ~last_grant;
    else                                  winner = req.req1_valid;
    last_bit = (cnt == LAST);
    load     = ~rst & ~stall & any_valid & ((state == IDLE) | last_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    piso_enb       = 1'b0;
    piso_l_s       = 1'b0;
    piso_inp       = '0;
    req.req0_ready = 1'b0;
    req.req1_ready = 1'b0;
    if (load) begin
      piso_enb       = 1'b1;
      piso_l_s       = 1'b1;
      piso_inp       = winner ? req.req1_data : req.req0_data;
      req.req0_ready = ~winner;
      req.req1_ready = winner;
      grant_id_nxt   = winner;
      last_grant_nxt = winner;
      cnt_nxt        = '0;
      state_nxt      = SHIFT;
    end else if (state == SHIFT && !stall && !rst) begin
      // Last bit with nothing waiting: leave the serializer frozen and go idle.
      if (last_bit) begin
        state_nxt = IDLE;
      end else begin
        piso_enb = 1'b1;
        cnt_nxt  = cnt + 1'b1;
      end
    end
  end

  assign busy        = (state == SHIFT);
  assign frame_valid = busy & ~stall;
  assign sof         = frame_valid & (cnt == '0);
  assign eof         = frame_valid & last_bit;
  assign dbg_state   = state;

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Directed bench for piso_arb_ctrl with a behavioural rotating PISO on its outputs.
module tb_piso_arb_ctrl;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          piso_enb, piso_l_s;
  logic [DW-1:0] piso_inp;
  logic          frame_valid, sof, eof, grant_id, busy, dbg_state;

  piso_arb_ctrl_if #(.DW(DW)) bus ();

  piso_arb_ctrl #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (bus),
    .stall       (stall),
    .piso_enb    (piso_enb),
    .piso_l_s    (piso_l_s),
    .piso_inp    (piso_inp),
    .frame_valid (frame_valid),
    .sof         (sof),
    .eof         (eof),
    .grant_id    (grant_id),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // serializer model: MSB out, rotates on shift
  logic [DW-1:0] sr;
  logic          serial;
  always @(posedge clk) begin
    if (piso_enb) sr <= piso_l_s ? piso_inp : {sr[DW-2:0], sr[DW-1]};
  end
  assign serial = sr[DW-1];

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {r0, r1, enb, l_s, fv, sof, eof, gid, busy}
  function automatic logic [8:0] ctl();
    return {bus.req0_ready, bus.req1_ready, piso_enb, piso_l_s,
            frame_valid, sof, eof, grant_id, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [8:0]    t1_ctl [5];
  logic [8:0]    t4_ctl [7];
  logic [3:0]    t4_ser [7];
  logic [3:0]    word;
  logic [8:0]    exp_c;
  logic          exp_r0, exp_r1, exp_ld, exp_gid;
  logic [DW-1:0] exp_inp;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    t1_ctl = '{9'b0_0_1_0_1_1_0_0_1, 9'b0_0_1_0_1_0_0_0_1, 9'b0_0_1_0_1_0_0_0_1,
               9'b0_0_0_0_1_0_1_0_1, 9'b0_0_0_0_0_0_0_0_0};
    t4_ctl = '{9'b0_0_1_0_1_1_0_0_1, 9'b0_0_0_0_0_0_0_0_1, 9'b0_0_0_0_0_0_0_0_1,
               9'b0_0_1_0_1_0_0_0_1, 9'b0_0_1_0_1_0_0_0_1, 9'b0_0_0_0_1_0_1_0_1,
               9'b0_0_0_0_0_0_0_0_0};
    t4_ser = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};

    // reset values, then single word 4'b1011 from req0
    do_reset();
    settle();
    check("rst_ctl", 32'(ctl()), 32'h0);
    check("rst_inp", 32'(piso_inp), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'hB;
    settle();
    check("t1_load_ctl", 32'(ctl()), 32'(9'b1_0_1_1_0_0_0_0_0));
    check("t1_load_inp", 32'(piso_inp), 32'hB);
    word = 4'hB;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.req0_valid = 1'b0;
      settle();
      check($sformatf("t1_ctl_c%0d", k), 32'(ctl()), 32'(t1_ctl[k-1]));
      if (k <= 4) check($sformatf("t1_ser_c%0d", k), 32'(serial), 32'(word[4-k]));
    end
    check("t1_inp_idle", 32'(piso_inp), 32'h0);

    // both requesters continuously valid: grants alternate 0,1,0,1,0
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'hA;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'h5;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      settle();
      exp_ld  = (k % 4 == 0);
      exp_r0  = exp_ld && ((k / 4) % 2 == 0);
      exp_r1  = exp_ld && ((k / 4) % 2 == 1);
      exp_gid = (k == 0) ? 1'b0 : 1'(((k - 1) / 4) % 2);
      exp_inp = exp_r0 ? 4'hA : (exp_r1 ? 4'h5 : 4'h0);
      exp_c   = {exp_r0, exp_r1, 1'b1, exp_ld, k > 0, k > 0 && k % 4 == 1,
                 k > 0 && k % 4 == 0, exp_gid, k > 0};
      check($sformatf("t2_ctl_c%0d", k), 32'(ctl()), 32'(exp_c));
      check($sformatf("t2_inp_c%0d", k), 32'(piso_inp), 32'(exp_inp));
      if (k > 0) begin
        word = exp_gid ? 4'h5 : 4'hA;
        check($sformatf("t2_ser_c%0d", k), 32'(serial), 32'(word[3 - ((k - 1) % 4)]));
      end
    end

    // req1 alone is granted at once; the following tie goes to req0
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'h6;
    settle();
    check("t3_load1_ctl", 32'(ctl()), 32'(9'b0_1_1_1_0_0_0_0_0));
    check("t3_load1_inp", 32'(piso_inp), 32'h6);
    tick();
    bus.req1_data  = 4'h9;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'h3;
    settle();
    check("t3_sof_ctl", 32'(ctl()), 32'(9'b0_0_1_0_1_1_0_1_1));
    tick();
    tick();
    tick();
    settle();
    check("t3_tie_ctl", 32'(ctl()), 32'(9'b1_0_1_1_1_0_1_1_1));
    check("t3_tie_inp", 32'(piso_inp), 32'h3);
    check("t3_tie_ser", 32'(serial), 32'h0);

    // two stall cycles while cnt==1
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'hB;
    settle();
    check("t4_load_ctl", 32'(ctl()), 32'(9'b1_0_1_1_0_0_0_0_0));
    for (int k = 1; k <= 7; k++) begin
      tick();
      bus.req0_valid = 1'b0;
      stall          = (k == 2 || k == 3);
      settle();
      check($sformatf("t4_ctl_c%0d", k), 32'(ctl()), 32'(t4_ctl[k-1]));
      if (k <= 6) check($sformatf("t4_ser_c%0d", k), 32'(serial), 32'(t4_ser[k-1]));
    end

    // stall in the eof cycle with req0 waiting
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'hC;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    tick();
    stall          = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'h9;
    settle();
    check("t5_stall_ctl", 32'(ctl()), 32'(9'b0_0_0_0_0_0_0_0_1));
    tick();
    stall = 1'b0;
    settle();
    check("t5_eof_load_ctl", 32'(ctl()), 32'(9'b1_0_1_1_1_0_1_0_1));
    check("t5_eof_load_inp", 32'(piso_inp), 32'h9);
    check("t5_eof_ser", 32'(serial), 32'h0);
    tick();
    bus.req0_valid = 1'b0;
    settle();
    check("t5_sof_ctl", 32'(ctl()), 32'(9'b0_0_1_0_1_1_0_0_1));
    check("t5_sof_ser", 32'(serial), 32'h1);

    // reset mid-frame at cnt==2 with req1 still holding a word
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'hA;
    settle();
    check("t6_load_ctl", 32'(ctl()), 32'(9'b0_1_1_1_0_0_0_0_0));
    tick();
    bus.req1_data = 4'h7;
    settle();
    check("t6_sof_ctl", 32'(ctl()), 32'(9'b0_0_1_0_1_1_0_1_1));
    tick();
    tick();
    rst = 1'b1;
    tick();
    settle();
    check("t6_rst_ctl", 32'(ctl()), 32'h0);
    check("t6_rst_inp", 32'(piso_inp), 32'h0);
    check("t6_rst_state", 32'(dbg_state), 32'h0);
    tick();
    rst = 1'b0;
    settle();
    check("t6_regrant_ctl", 32'(ctl()), 32'(9'b0_1_1_1_0_0_0_0_0));
    check("t6_regrant_inp", 32'(piso_inp), 32'h7);
    tick();
    bus.req1_valid = 1'b0;
    settle();
    check("t6_sof2_ctl", 32'(ctl()), 32'(9'b0_0_1_0_1_1_0_1_1));
    check("t6_sof2_ser", 32'(serial), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
